// File: rtl/fb_arb_pkg.sv
// Shared types and default sizing for the frame-buffer port arbiter.
package fb_arb_pkg;

    // Default geometry: 17-bit frame address, 24-bit RGB pixel.
    localparam int ADDR_W_DEF     = 17;
    localparam int DATA_W_DEF     = 24;
    // Longest run of tracker stall cycles tolerated before a forced grant.
    localparam int STARVE_MAX_DEF = 15;

    // Requester indices used for the per-port read-return lanes.
    localparam int PORT_DISP = 0;
    localparam int PORT_TRK  = 1;
    localparam int N_PORTS   = 2;

    // Arbitration policy states.
    typedef enum logic [1:0] {
        DISP_PRI = 2'd0,   // active video: display has priority
        TRK_PRI  = 2'd1,   // vertical blanking: tracker has priority
        STARVE   = 2'd2    // one forced tracker grant after a long stall
    } arb_state_t;

    // Width needed to hold the values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/fb_arb_starve_ctr.sv
// Saturating count of consecutive tracker stall cycles.
module fb_arb_starve_ctr
    import fb_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int CNT_W      = cnt_width(STARVE_MAX)
) (
    input  logic CLK,
    input  logic nRESET,
    input  logic stall,   // tracker requesting but not granted this cycle
    input  logic clear,   // tracker transfer this cycle
    output logic reach    // this stall cycle brings the count to STARVE_MAX
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    // Next count: a transfer clears, a stall counts up and sticks at the limit.
    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (stall && (count_reg != MAX_C)) begin
            count_next = count_reg + 1'b1;
        end
    end

    // Only a genuine stall may trigger the forced grant; a saturated count
    // with the tracker idle must not pull the arbiter into STARVE.
    assign reach = stall && (count_next == MAX_C);

    // Count register.
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Two-port arbiter in front of a single-port frame BRAM: display scanout
// versus tracker/overlay, with vblank-driven priority and starvation relief.
module fb_port_arbiter
    import fb_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              CLK,
    input  logic              nRESET,
    input  logic              vblank,
    // display scanout port (read only)
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    // tracker / overlay port (read or write)
    input  logic              trk_req,
    input  logic              trk_we,
    input  logic [ADDR_W-1:0] trk_addr,
    input  logic [DATA_W-1:0] trk_wdata,
    output logic              trk_gnt,
    output logic              trk_rvalid,
    output logic [DATA_W-1:0] trk_rdata,
    // single-port BRAM
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata,
    // status
    output logic              disp_underrun
);

    arb_state_t state_reg;
    arb_state_t state_next;

    logic disp_xfer;
    logic trk_xfer;
    logic trk_stall;
    logic starve_reach;

    // BRAM issue stage
    logic              bram_en_reg;
    logic              bram_we_reg;
    logic [ADDR_W-1:0] bram_addr_reg;
    logic [DATA_W-1:0] bram_wdata_reg;
    // which port (if any) owns the read currently on the BRAM port
    logic [N_PORTS-1:0] rd_tag_reg;
    logic [N_PORTS-1:0] rd_tag_next;

    // read-return stage, one lane per port
    logic [N_PORTS-1:0] rvalid_reg;
    logic [DATA_W-1:0]  rdata_port [N_PORTS];

    // underrun tracking
    logic vblank_reg;
    logic vblank_rise;
    logic underrun_reg;
    logic underrun_next;

    // Grants: combinational from requests and the registered policy state.
    // STARVE behaves like TRK_PRI for one cycle, giving the tracker the slot.
    always_comb begin
        disp_gnt = 1'b0;
        trk_gnt  = 1'b0;
        if (nRESET) begin
            case (state_reg)
                DISP_PRI: begin
                    disp_gnt = disp_req;
                    trk_gnt  = trk_req & ~disp_req;
                end
                TRK_PRI, STARVE: begin
                    trk_gnt  = trk_req;
                    disp_gnt = disp_req & ~trk_req;
                end
                default: begin
                    disp_gnt = 1'b0;
                    trk_gnt  = 1'b0;
                end
            endcase
        end
    end

    assign disp_xfer = disp_req & disp_gnt;
    assign trk_xfer  = trk_req & trk_gnt;
    assign trk_stall = trk_req & ~trk_gnt;

    fb_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .CLK    (CLK),
        .nRESET (nRESET),
        .stall  (trk_stall),
        .clear  (trk_xfer),
        .reach  (starve_reach)
    );

    // Next policy state: vblank is followed one cycle late, the starvation
    // trigger only applies in DISP_PRI and takes precedence over vblank there;
    // STARVE lasts one cycle and then picks up whatever vblank says.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            DISP_PRI: begin
                if (starve_reach) begin
                    state_next = STARVE;
                end else if (vblank) begin
                    state_next = TRK_PRI;
                end
            end
            TRK_PRI: begin
                if (!vblank) begin
                    state_next = DISP_PRI;
                end
            end
            STARVE: begin
                state_next = vblank ? TRK_PRI : DISP_PRI;
            end
            default: begin
                state_next = DISP_PRI;
            end
        endcase
    end

    // Policy state register.
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            state_reg <= DISP_PRI;
        end else begin
            state_reg <= state_next;
        end
    end

    // Read-tag for the access being issued: a write never produces a return.
    always_comb begin
        rd_tag_next = '0;
        if (disp_xfer) begin
            rd_tag_next[PORT_DISP] = 1'b1;
        end else if (trk_xfer && !trk_we) begin
            rd_tag_next[PORT_TRK] = 1'b1;
        end
    end

    // Issue stage: register the winning request onto the BRAM port.
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            bram_en_reg    <= 1'b0;
            bram_we_reg    <= 1'b0;
            bram_addr_reg  <= '0;
            bram_wdata_reg <= '0;
            rd_tag_reg     <= '0;
        end else begin
            bram_en_reg <= disp_xfer | trk_xfer;
            rd_tag_reg  <= rd_tag_next;
            if (disp_xfer) begin
                bram_we_reg    <= 1'b0;
                bram_addr_reg  <= disp_addr;
                bram_wdata_reg <= '0;
            end else if (trk_xfer) begin
                bram_we_reg    <= trk_we;
                bram_addr_reg  <= trk_addr;
                bram_wdata_reg <= trk_wdata;
            end else begin
                // idle slot: keep address/data, but never leave a write armed
                bram_we_reg <= 1'b0;
            end
        end
    end

    assign bram_en    = bram_en_reg;
    assign bram_we    = bram_we_reg;
    assign bram_addr  = bram_addr_reg;
    assign bram_wdata = bram_wdata_reg;

    // Return lanes: rvalid is registered alongside the BRAM's own output
    // register, so read data is taken straight from bram_rdata and gated to
    // zero whenever the lane is not valid (and therefore also in reset).
    generate
        for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_ret
            // Valid follows the tagged BRAM read by one cycle.
            always_ff @(posedge CLK) begin
                if (!nRESET) begin
                    rvalid_reg[gi] <= 1'b0;
                end else begin
                    rvalid_reg[gi] <= bram_en_reg & ~bram_we_reg & rd_tag_reg[gi];
                end
            end
            assign rdata_port[gi] = rvalid_reg[gi] ? bram_rdata : '0;
        end
    endgenerate

    assign disp_rvalid = rvalid_reg[PORT_DISP];
    assign disp_rdata  = rdata_port[PORT_DISP];
    assign trk_rvalid  = rvalid_reg[PORT_TRK];
    assign trk_rdata   = rdata_port[PORT_TRK];

    // Underrun flag: a display stall sets it, the cycle after a vblank rising
    // edge clears it, and a stall in that same cycle keeps it set.
    assign vblank_rise = vblank & ~vblank_reg;

    always_comb begin
        underrun_next = underrun_reg;
        if (disp_req && !disp_gnt) begin
            underrun_next = 1'b1;
        end else if (vblank_rise) begin
            underrun_next = 1'b0;
        end
    end

    // Underrun flag and vblank edge-detect registers.
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            underrun_reg <= 1'b0;
            vblank_reg   <= 1'b0;
        end else begin
            underrun_reg <= underrun_next;
            vblank_reg   <= vblank;
        end
    end

    assign disp_underrun = underrun_reg;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a small behavioural BRAM.
module tb_fb_port_arbiter;

    logic        CLK = 1'b0;
    logic        nRESET;
    logic        vblank;
    logic        disp_req;
    logic [16:0] disp_addr;
    logic        disp_gnt;
    logic        disp_rvalid;
    logic [23:0] disp_rdata;
    logic        trk_req;
    logic        trk_we;
    logic [16:0] trk_addr;
    logic [23:0] trk_wdata;
    logic        trk_gnt;
    logic        trk_rvalid;
    logic [23:0] trk_rdata;
    logic        bram_en;
    logic        bram_we;
    logic [16:0] bram_addr;
    logic [23:0] bram_wdata;
    logic [23:0] bram_rdata;
    logic        disp_underrun;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    fb_port_arbiter #(
        .ADDR_W     (17),
        .DATA_W     (24),
        .STARVE_MAX (15)
    ) dut (
        .CLK           (CLK),
        .nRESET        (nRESET),
        .vblank        (vblank),
        .disp_req      (disp_req),
        .disp_addr     (disp_addr),
        .disp_gnt      (disp_gnt),
        .disp_rvalid   (disp_rvalid),
        .disp_rdata    (disp_rdata),
        .trk_req       (trk_req),
        .trk_we        (trk_we),
        .trk_addr      (trk_addr),
        .trk_wdata     (trk_wdata),
        .trk_gnt       (trk_gnt),
        .trk_rvalid    (trk_rvalid),
        .trk_rdata     (trk_rdata),
        .bram_en       (bram_en),
        .bram_we       (bram_we),
        .bram_addr     (bram_addr),
        .bram_wdata    (bram_wdata),
        .bram_rdata    (bram_rdata),
        .disp_underrun (disp_underrun)
    );

    // Behavioural BRAM: 32 words preloaded with 0x100000 + index, one-cycle read.
    logic [23:0] mem [32];
    always @(posedge CLK) begin
        if (!nRESET) begin
            for (int i = 0; i < 32; i++) mem[i] <= 24'h100000 + 24'(i);
            bram_rdata <= '0;
        end else if (bram_en) begin
            if (bram_we) mem[bram_addr[4:0]] <= bram_wdata;
            else         bram_rdata <= mem[bram_addr[4:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // ---- reset: grants held low even with both requesting ----
        nRESET = 1'b0; vblank = 1'b0;
        disp_req = 1'b1; disp_addr = '0;
        trk_req = 1'b1; trk_we = 1'b0; trk_addr = '0; trk_wdata = '0;
        repeat (2) begin
            @(negedge CLK);
            chk("rst_disp_gnt", disp_gnt, 0);
            chk("rst_trk_gnt", trk_gnt, 0);
            chk("rst_bram_en", bram_en, 0);
            chk("rst_disp_rvalid", disp_rvalid, 0);
            chk("rst_underrun", disp_underrun, 0);
            next_cycle();
        end
        nRESET = 1'b1;
        trk_req = 1'b0;

        // ---- display streams addresses 0..7 in active video ----
        for (int k = 0; k < 11; k++) begin
            disp_req  = (k < 8);
            disp_addr = (k < 8) ? 17'(k) : 17'd0;
            @(negedge CLK);
            chk("p1_disp_gnt", disp_gnt, (k < 8));
            chk("p1_trk_gnt", trk_gnt, 0);
            chk("p1_bram_en", bram_en, (k >= 1 && k <= 8));
            if (k >= 1 && k <= 8) chk("p1_bram_addr", bram_addr, k - 1);
            chk("p1_disp_rvalid", disp_rvalid, (k >= 2 && k <= 9));
            if (k >= 2 && k <= 9) chk("p1_disp_rdata", disp_rdata, 24'h100000 + 24'(k - 2));
            chk("p1_trk_rvalid", trk_rvalid, 0);
            next_cycle();
        end

        // ---- both requesting in active video: tracker gets 1 slot in 16 ----
        // vblank rises at j=31 while the display is stalled by STARVE.
        for (int j = 0; j < 32; j++) begin
            disp_req = 1'b1; disp_addr = 17'(j & 7);
            trk_req = 1'b1; trk_we = 1'b0; trk_addr = 17'd3;
            vblank = (j == 31);
            @(negedge CLK);
            chk("p2_trk_gnt", trk_gnt, (j == 15 || j == 31));
            chk("p2_disp_gnt", disp_gnt, !(j == 15 || j == 31));
            if (j == 15) chk("p2_underrun_clear", disp_underrun, 0);
            if (j == 16) chk("p2_underrun_set", disp_underrun, 1);
            if (j == 17) begin
                chk("p2_trk_rvalid", trk_rvalid, 1);
                chk("p2_trk_rdata", trk_rdata, 24'h100003);
                chk("p2_disp_rvalid_slot", disp_rvalid, 0);
            end
            if (j == 18) begin
                chk("p2_trk_rvalid_off", trk_rvalid, 0);
                chk("p2_disp_rvalid", disp_rvalid, 1);
                chk("p2_disp_rdata", disp_rdata, 24'h100000);
            end
            next_cycle();
        end

        // ---- vblank: tracker wins every cycle; set beat clear at the rise ----
        for (int j = 32; j < 35; j++) begin
            @(negedge CLK);
            chk("p3_trk_gnt", trk_gnt, 1);
            chk("p3_disp_gnt", disp_gnt, 0);
            chk("p3_underrun", disp_underrun, 1);
            if (j == 33) chk("p3_trk_rdata", trk_rdata, 24'h100003);
            next_cycle();
        end

        // c35: tracker writes 0xABCDEF to address 5
        trk_we = 1'b1; trk_addr = 17'd5; trk_wdata = 24'hABCDEF;
        @(negedge CLK);
        chk("c35_trk_gnt", trk_gnt, 1);
        chk("c35_trk_rvalid", trk_rvalid, 1);
        next_cycle();

        // c36: vblank falls, display reads address 5
        trk_req = 1'b0; trk_we = 1'b0; vblank = 1'b0;
        disp_req = 1'b1; disp_addr = 17'd5;
        @(negedge CLK);
        chk("c36_disp_gnt", disp_gnt, 1);
        chk("c36_bram_we", bram_we, 1);
        chk("c36_bram_addr", bram_addr, 5);
        chk("c36_bram_wdata", bram_wdata, 24'hABCDEF);
        next_cycle();

        // c37: the write returns nothing; the read is on the BRAM port
        disp_req = 1'b0;
        @(negedge CLK);
        chk("c37_trk_rvalid_wr", trk_rvalid, 0);
        chk("c37_bram_en", bram_en, 1);
        chk("c37_bram_we", bram_we, 0);
        next_cycle();

        // c38: display sees the tracker's pixel
        @(negedge CLK);
        chk("c38_disp_rvalid", disp_rvalid, 1);
        chk("c38_disp_rdata", disp_rdata, 24'hABCDEF);
        chk("c38_underrun", disp_underrun, 1);
        next_cycle();

        // c39: vblank rises with no display stall
        vblank = 1'b1; disp_req = 1'b1; disp_addr = 17'd0;
        @(negedge CLK);
        chk("c39_disp_gnt", disp_gnt, 1);
        chk("c39_underrun", disp_underrun, 1);
        next_cycle();

        // c40: flag cleared
        disp_req = 1'b0;
        @(negedge CLK);
        chk("c40_underrun_cleared", disp_underrun, 0);
        next_cycle();

        // c41: display read of address 5, then reset in the following cycle
        vblank = 1'b0; disp_req = 1'b1; disp_addr = 17'd5;
        @(negedge CLK);
        chk("c41_disp_gnt", disp_gnt, 1);
        chk("c41_disp_rdata", disp_rdata, 24'h100000);
        next_cycle();

        // c42: reset asserted with both requesting
        nRESET = 1'b0; trk_req = 1'b1;
        @(negedge CLK);
        chk("c42_disp_gnt", disp_gnt, 0);
        chk("c42_trk_gnt", trk_gnt, 0);
        chk("c42_bram_en", bram_en, 1);
        next_cycle();

        // c43: released, everything registered is back to zero
        nRESET = 1'b1; disp_req = 1'b0; trk_req = 1'b0;
        @(negedge CLK);
        chk("c43_bram_en", bram_en, 0);
        chk("c43_bram_we", bram_we, 0);
        chk("c43_bram_addr", bram_addr, 0);
        chk("c43_bram_wdata", bram_wdata, 0);
        chk("c43_disp_rvalid", disp_rvalid, 0);
        chk("c43_disp_rdata", disp_rdata, 0);
        chk("c43_trk_rvalid", trk_rvalid, 0);
        chk("c43_trk_rdata", trk_rdata, 0);
        chk("c43_underrun", disp_underrun, 0);
        next_cycle();

        // c44: the read issued before reset never returns
        @(negedge CLK);
        chk("c44_disp_rvalid", disp_rvalid, 0);
        chk("c44_bram_en", bram_en, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fb_port_arbiter.md
FB_PORT_ARBITER -- requirements
Module: fb_port_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 17, frame BRAM address width; DATA_W, default 24, RGB pixel width; STARVE_MAX, default 15, maximum consecutive tracker stall cycles.
REQ-002 CLK  input  1  clock; all logic SHALL be rising-edge CLK only.
REQ-003 nRESET  input  1  reset, synchronous, active-low.
REQ-004 vblank  input  1  high during vertical blanking, synchronous to CLK.
REQ-005 disp_req  input  1  display scanout read request.
REQ-006 disp_addr  input  ADDR_W  display read address.
REQ-007 disp_gnt  output  1  display handshake accept.
REQ-008 disp_rvalid  output  1  display read data valid.
REQ-009 disp_rdata  output  DATA_W  display read data.
REQ-010 trk_req  input  1  tracker/overlay request.
REQ-011 trk_we  input  1  tracker write, 1 = write, 0 = read.
REQ-012 trk_addr  input  ADDR_W  tracker address.
REQ-013 trk_wdata  input  DATA_W  tracker write data.
REQ-014 trk_gnt  output  1  tracker handshake accept.
REQ-015 trk_rvalid  output  1  tracker read data valid.
REQ-016 trk_rdata  output  DATA_W  tracker read data.
REQ-017 bram_en, bram_we  output  1 each  single-port BRAM enable and write enable.
REQ-018 bram_addr, bram_wdata  output  ADDR_W / DATA_W  BRAM address and write data.
REQ-019 bram_rdata  input  DATA_W  BRAM read data, valid one cycle after bram_en.
REQ-020 disp_underrun  output  1  sticky flag: display request stalled.

Function
REQ-021 Transfer: a transfer SHALL occur in a cycle with req and gnt both high; req, addr, we and wdata SHALL be held stable by the requester until gnt.
REQ-022 Gnt SHALL be combinational from req and registered state; at most one of disp_gnt and trk_gnt SHALL be high per cycle; gnt SHALL never be high without its req.
REQ-023 Transfer in cycle N SHALL drive bram_en=1 with registered addr/we/wdata in cycle N+1; a read SHALL return rvalid=1 with rdata=bram_rdata in cycle N+2 to the originating port only.
REQ-024 Back-to-back transfers SHALL sustain 1 per cycle; no bubble between grants.
REQ-025 FSM states: DISP_PRI, TRK_PRI, STARVE.
REQ-026 DISP_PRI (vblank=0): display wins on conflict; tracker granted only when disp_req=0.
REQ-027 TRK_PRI (vblank=1): tracker wins on conflict.
REQ-028 starve_cnt SHALL increment each cycle trk_req=1 and trk_gnt=0, saturating at STARVE_MAX, and clear on any tracker transfer.
REQ-029 DISP_PRI -> STARVE when starve_cnt reaches STARVE_MAX; STARVE grants tracker unconditionally for exactly one cycle, then returns to DISP_PRI or TRK_PRI per vblank.
REQ-030 DISP_PRI <-> TRK_PRI transitions SHALL follow vblank with one-cycle latency; vblank changes while in STARVE are applied on exit.
REQ-031 disp_underrun SHALL set in any cycle with disp_req=1 and disp_gnt=0, and clear on the cycle after a vblank rising edge unless set again that cycle; set wins over clear.
REQ-032 Writes SHALL produce no rvalid; bram_en=0 in cycles following no transfer.

Reset
REQ-033 nRESET=0 SHALL force state DISP_PRI, starve_cnt=0, underrun=0, and all registered outputs (bram_en, bram_we, bram_addr, bram_wdata, rvalid, rdata) to 0.
REQ-034 Reads in flight at reset SHALL be discarded: no rvalid in the two cycles after release.
REQ-035 gnt SHALL be 0 while nRESET=0.

Structure
REQ-036 Package fb_arb_pkg SHALL hold the state enum and default ADDR_W, DATA_W, STARVE_MAX constants.
REQ-037 The saturating starvation counter SHALL be the sub-module fb_arb_starve_ctr; everything else stays in fb_port_arbiter.

Verification
REQ-038 disp_req continuous, addr 0..7, vblank=0 -> disp_gnt every cycle; disp_rvalid from cycle 2 onward with rdata = mem[0..7] in order.
REQ-039 disp_req and trk_req both continuous, vblank=0, STARVE_MAX=15 -> trk_gnt exactly once every 16 cycles; disp_underrun=1.
REQ-040 vblank=1 with both requesting -> trk_gnt every cycle; a trk write of 0xABCDEF to addr 5, then a display read of addr 5 after vblank falls -> rdata 0xABCDEF.
REQ-041 nRESET pulsed low in the cycle after a display read transfer -> no disp_rvalid in the next 2 cycles; all outputs 0.
REQ-042 disp_underrun set, then vblank rises with no stall -> flag clears the next cycle; with a simultaneous stall -> flag stays 1.
